// File: rtl/branch_update_queue_pkg.sv
// branch_update_queue_pkg: entry layout and history helpers shared by the branch update queue.
`ifndef BRANCH_HISTORY_REG_SZ
`define BRANCH_HISTORY_REG_SZ 4
`endif
package branch_update_queue_pkg;
    localparam int ADDR_W = 32;
    localparam int BHR_W = `BRANCH_HISTORY_REG_SZ;

    typedef logic [BHR_W-1:0] bhr_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
        bhr_t              bhr;
        logic              resolved;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } bq_entry_t;

    function automatic bhr_t bhr_shift(bhr_t h, logic b);
        return {h[BHR_W-2:0], b};
    endfunction
endpackage

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order queue of in-flight branches owning the speculative
// history, repairing it on mispredict and feeding predictor updates at commit.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int BHR_DEPTH = BHR_W,
    parameter int DEPTH = 8,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 disp_valid,
    input  logic [ADDR_W-1:0]    disp_pc,
    input  logic                 disp_pred_taken,
    input  logic [ADDR_W-1:0]    disp_pred_target,
    output logic                 disp_ready,
    output logic [TAG_W-1:0]     disp_tag,
    output logic [BHR_DEPTH-1:0] spec_bhr,
    input  logic                 res_valid,
    input  logic [TAG_W-1:0]     res_tag,
    input  logic                 res_taken,
    input  logic [ADDR_W-1:0]    res_target,
    output logic                 mispredict,
    output logic [ADDR_W-1:0]    mispredict_pc,
    input  logic                 commit_valid,
    output logic                 head_resolved,
    output logic                 wr_en,
    output logic                 wr_taken,
    output logic [ADDR_W-1:0]    wr_target,
    output logic [ADDR_W-1:0]    wr_pc,
    output logic [BHR_DEPTH-1:0] wr_bhr,
    output logic                 full,
    output logic                 empty
);
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   ptr_t;

    bq_entry_t        q [DEPTH];
    bq_entry_t        new_e;
    ptr_t             head, tail, res_ptr;
    tag_t             head_idx, tail_idx;
    bhr_t             bhr_q;
    logic [DEPTH-1:0] kill;
    logic             res_hit, res_mis, disp_fire, commit_fire;

    assign head_idx      = head[TAG_W-1:0];
    assign tail_idx      = tail[TAG_W-1:0];
    assign full          = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign empty         = head == tail;
    assign res_hit       = res_valid & q[res_tag].valid;
    assign res_mis       = res_hit & ((res_taken != q[res_tag].pred_taken) |
                                      (res_taken & (res_target != q[res_tag].pred_target)));
    assign disp_ready    = ~full & ~res_mis;
    assign disp_fire     = disp_valid & disp_ready;
    assign head_resolved = q[head_idx].valid & q[head_idx].resolved;
    assign commit_fire   = commit_valid & ~empty & head_resolved;
    assign disp_tag      = tail_idx;
    assign spec_bhr      = bhr_q;
    // slots below the head index belong to the next lap of the pointer
    assign res_ptr       = {(res_tag >= head_idx) ? head[TAG_W] : ~head[TAG_W], res_tag};

    always_comb begin
        new_e = '0;
        new_e.valid = 1'b1;
        new_e.pc = disp_pc;
        new_e.pred_taken = disp_pred_taken;
        new_e.pred_target = disp_pred_target;
        new_e.bhr = bhr_q;
    end

    // younger than the mispredicting branch means further from the head in age order
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++)
            kill[i] = res_mis && (tag_t'(tag_t'(i) - head_idx) > tag_t'(res_tag - head_idx));
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        bq_entry_t e;
        assign q[g] = e;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                e <= '0;
            end else begin
                if (disp_fire && tail_idx == tag_t'(g))
                    e <= new_e;
                if (res_hit && res_tag == tag_t'(g)) begin
                    e.resolved <= 1'b1;
                    e.taken <= res_taken;
                    e.target <= res_target;
                end
                if (kill[g] || (commit_fire && head_idx == tag_t'(g)))
                    e.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            bhr_q <= '0;
            mispredict <= 1'b0;
            mispredict_pc <= '0;
            wr_en <= 1'b0;
            wr_taken <= 1'b0;
            wr_target <= '0;
            wr_pc <= '0;
            wr_bhr <= '0;
        end else begin
            head <= commit_fire ? head + 1'b1 : head;
            tail <= res_mis ? res_ptr + 1'b1 : disp_fire ? tail + 1'b1 : tail;
            bhr_q <= res_mis ? bhr_shift(q[res_tag].bhr, res_taken) :
                     disp_fire ? bhr_shift(bhr_q, disp_pred_taken) : bhr_q;
            mispredict <= res_mis;
            if (res_mis)
                mispredict_pc <= res_taken ? res_target : q[res_tag].pc + ADDR_W'(4);
            wr_en <= commit_fire;
            if (commit_fire) begin
                wr_taken <= q[head_idx].taken;
                wr_target <= q[head_idx].target;
                wr_pc <= q[head_idx].pc;
                wr_bhr <= q[head_idx].bhr;
            end
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed and random stimulus against a queue-of-records model
// of the in-flight branch list, speculative history and predictor update port.
module tb_branch_update_queue;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        disp_valid = 1'b0, disp_pred_taken = 1'b0;
    logic [31:0] disp_pc = '0, disp_pred_target = '0;
    logic        disp_ready;
    logic [1:0]  disp_tag;
    logic [3:0]  spec_bhr;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic [1:0]  res_tag = '0;
    logic [31:0] res_target = '0;
    logic        mispredict;
    logic [31:0] mispredict_pc;
    logic        commit_valid = 1'b0;
    logic        head_resolved, wr_en, wr_taken, full, empty;
    logic [31:0] wr_target, wr_pc;
    logic [3:0]  wr_bhr;

    branch_update_queue #(.BHR_DEPTH(4), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
        .disp_pred_target(disp_pred_target), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .spec_bhr(spec_bhr),
        .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .commit_valid(commit_valid), .head_resolved(head_resolved),
        .wr_en(wr_en), .wr_taken(wr_taken), .wr_target(wr_target), .wr_pc(wr_pc), .wr_bhr(wr_bhr),
        .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        int          bhr;
        logic        res;
        logic        tk;
        logic [31:0] tgt;
    } rec_t;

    rec_t        mq[$];
    int          m_tail, m_bhr, total, bad;
    logic        e_wr, e_mis, e_wtk;
    logic [31:0] e_wtgt, e_wpc, e_mpc;
    int          e_wbhr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        chk("wr_en", 32'(wr_en), 32'(e_wr));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        if (e_wr) begin
            chk("wr_taken", 32'(wr_taken), 32'(e_wtk));
            chk("wr_target", wr_target, e_wtgt);
            chk("wr_pc", wr_pc, e_wpc);
            chk("wr_bhr", 32'(wr_bhr), e_wbhr);
        end
        if (e_mis) chk("mispredict_pc", mispredict_pc, e_mpc);
        chk("spec_bhr", 32'(spec_bhr), m_bhr);
        chk("full", 32'(full), 32'(mq.size() == 4));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("disp_tag", 32'(disp_tag), m_tail);
        chk("head_resolved", 32'(head_resolved), 32'(mq.size() > 0 && mq[0].res));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        disp_valid = 1'b0;
        res_valid = 1'b0;
        commit_valid = 1'b0;
        #1;
        chk({tag, ":wr_en"}, 32'(wr_en), 0);
        chk({tag, ":mispredict"}, 32'(mispredict), 0);
        chk({tag, ":mispredict_pc"}, mispredict_pc, 0);
        chk({tag, ":wr_taken"}, 32'(wr_taken), 0);
        chk({tag, ":wr_target"}, wr_target, 0);
        chk({tag, ":wr_pc"}, wr_pc, 0);
        chk({tag, ":wr_bhr"}, 32'(wr_bhr), 0);
        chk({tag, ":empty"}, 32'(empty), 1);
        chk({tag, ":full"}, 32'(full), 0);
        chk({tag, ":spec_bhr"}, 32'(spec_bhr), 0);
        chk({tag, ":disp_tag"}, 32'(disp_tag), 0);
        mq.delete();
        m_tail = 0;
        m_bhr = 0;
        e_wr = 1'b0;
        e_mis = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // called just after a falling edge; returns on the next falling edge
    task automatic step(input logic dv, input logic [31:0] dpc, input logic dpt, input logic [31:0] dtgt,
                        input logic rv, input int rtag, input logic rt, input logic [31:0] rtgt,
                        input logic cv);
        int   ri = -1;
        logic hit, mis, ready, cfire;
        rec_t r;
        disp_valid = dv;
        disp_pc = dpc;
        disp_pred_taken = dpt;
        disp_pred_target = dtgt;
        res_valid = rv;
        res_tag = 2'(rtag);
        res_taken = rt;
        res_target = rtgt;
        commit_valid = cv;
        if (rv) foreach (mq[i]) if (mq[i].tag == rtag) ri = i;
        hit = ri >= 0;
        mis = hit && (rt != mq[ri].pt || (rt && rtgt != mq[ri].ptgt));
        ready = mq.size() < 4 && !mis;
        cfire = cv && mq.size() > 0 && mq[0].res;
        #1;
        chk("disp_ready", 32'(disp_ready), 32'(ready));
        e_wr = cfire;
        e_mis = mis;
        if (cfire) begin
            e_wtk = mq[0].tk;
            e_wtgt = mq[0].tgt;
            e_wpc = mq[0].pc;
            e_wbhr = mq[0].bhr;
        end
        if (hit) begin
            r = mq[ri];
            if (mis) e_mpc = rt ? rtgt : r.pc + 32'd4;
            r.res = 1'b1;
            r.tk = rt;
            r.tgt = rtgt;
            mq[ri] = r;
        end
        if (mis) begin
            while (mq.size() > ri + 1) void'(mq.pop_back());
            m_bhr = (mq[ri].bhr * 2 + int'(rt)) % 16;
            m_tail = (mq[ri].tag + 1) % 4;
        end else if (dv && ready) begin
            r = '{tag: m_tail, pc: dpc, pt: dpt, ptgt: dtgt, bhr: m_bhr, res: 1'b0, tk: 1'b0, tgt: '0};
            mq.push_back(r);
            m_bhr = (m_bhr * 2 + int'(dpt)) % 16;
            m_tail = (m_tail + 1) % 4;
        end
        if (cfire) void'(mq.pop_front());
        @(posedge clock);
        #1;
        check_state();
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic disp(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        step(1'b1, pc, pt, tgt, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input int tag, input logic tk, input logic [31:0] tgt);
        step(1'b0, '0, 1'b0, '0, 1'b1, tag, tk, tgt, 1'b0);
    endtask

    task automatic rand_step();
        int          sz = mq.size();
        logic        rv, cv, rt;
        int          rtag;
        logic [31:0] rtgt;
        rv = 1'($urandom_range(0, 1));
        cv = 1'($urandom_range(0, 1));
        if (sz > 0 && $urandom_range(0, 3) != 0) begin
            int k = int'($urandom_range(0, sz - 1));
            rtag = mq[k].tag;
            rt = ($urandom_range(0, 3) == 0) ? !mq[k].pt : mq[k].pt;
            rtgt = ($urandom_range(0, 3) == 0) ? 32'h300 : mq[k].ptgt;
        end else begin
            rtag = int'($urandom_range(0, 3));
            rt = 1'($urandom_range(0, 1));
            rtgt = $urandom_range(0, 1) != 0 ? 32'h100 : 32'h200;
        end
        if (cv && sz > 0 && mq[0].res && rtag == mq[0].tag) rv = 1'b0;
        step($urandom_range(0, 2) != 0, $urandom & ~32'h3, 1'($urandom_range(0, 1)),
             $urandom_range(0, 1) != 0 ? 32'h100 : 32'h200, rv, rtag, rt, rtgt, cv);
    endtask

    initial begin
        total = 0;
        bad = 0;
        do_reset("rst0");
        disp(32'h1000, 1'b1, 32'h100);
        chk("bhr_after1", 32'(spec_bhr), 32'h1);
        disp(32'h1004, 1'b0, 32'h100);
        chk("bhr_after2", 32'(spec_bhr), 32'h2);
        disp(32'h1008, 1'b1, 32'h100);
        chk("bhr_after3", 32'(spec_bhr), 32'h5);
        chk("not_empty", 32'(empty), 0);
        disp(32'h100c, 1'b1, 32'h100);
        chk("full4", 32'(full), 1);
        chk("ready_when_full", 32'(disp_ready), 0);
        disp(32'h1010, 1'b0, 32'h200);
        chk("tail_kept", 32'(disp_tag), 0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1);
        chk("no_wr_unresolved", 32'(wr_en), 0);
        resolve(0, 1'b1, 32'h100);
        step(1'b1, 32'h1010, 1'b0, 32'h200, 1'b0, 0, 1'b0, '0, 1'b1);
        chk("commit_on_full_pc", wr_pc, 32'h1000);
        chk("full_after_commit", 32'(full), 0);
        idle();
        chk("wr_en_one_cycle", 32'(wr_en), 0);

        do_reset("rst1");
        disp(32'h2000, 1'b1, 32'h100);
        disp(32'h2004, 1'b1, 32'h100);
        disp(32'h2008, 1'b1, 32'h100);
        resolve(1, 1'b0, 32'h0);
        chk("mis_pulse", 32'(mispredict), 1);
        chk("mis_pc", mispredict_pc, 32'h2008);
        chk("bhr_repaired", 32'(spec_bhr), 32'h2);
        resolve(2, 1'b0, 32'h0);
        chk("killed_ignored", 32'(mispredict), 0);
        resolve(0, 1'b1, 32'h100);
        step(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0, 1'b1);
        chk("wr_en_commit", 32'(wr_en), 1);
        chk("wr_taken0", 32'(wr_taken), 1);
        chk("wr_target0", wr_target, 32'h100);
        chk("wr_bhr0", 32'(wr_bhr), 0);
        chk("wr_pc0", wr_pc, 32'h2000);

        do_reset("rst2");
        disp(32'h3000, 1'b1, 32'h100);
        disp(32'h3004, 1'b1, 32'h100);
        disp(32'h3008, 1'b1, 32'h100);
        resolve(2, 1'b0, 32'h0);
        chk("mis_pending", 32'(mispredict), 1);
        do_reset("rst_mid");

        for (int n = 0; n < 1500; n++) rand_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
